// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter (and the future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS            = 8;
    localparam int   UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam logic UART_IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter launched by a rising edge of t_ctrl.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] t_data,
    input  logic       t_ctrl,
    output logic       t_state,
    output logic       txd
);

    uart_tx_state_t state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] idx, idx_n;
    logic       txd_n, t_state_n;
    logic       ctrl_q;
    logic       launch;
    logic       tick;
`ifdef UART_TX_PARITY_EN
    logic       parity, parity_n;
`endif

    assign launch = t_ctrl & ~ctrl_q;

    // The counter is held clear in IDLE so START always gets a full bit time.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // ctrl_q resets high so a request held through reset is not treated as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            idx     <= '0;
            txd     <= UART_IDLE_LEVEL;
            t_state <= 1'b1;
            ctrl_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            idx     <= idx_n;
            txd     <= txd_n;
            t_state <= t_state_n;
            ctrl_q  <= t_ctrl;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        idx_n     = idx;
        txd_n     = txd;
        t_state_n = t_state;
`ifdef UART_TX_PARITY_EN
        parity_n  = parity;
`endif
        case (state)
            IDLE: begin
                if (launch) begin
                    shift_n   = t_data;
                    idx_n     = '0;
                    txd_n     = 1'b0;
                    t_state_n = 1'b0;
                    state_n   = START;
`ifdef UART_TX_PARITY_EN
                    parity_n  = ^t_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    txd_n   = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (idx == 3'(UART_DATA_BITS - 1)) begin
                        idx_n   = '0;
`ifdef UART_TX_PARITY_EN
                        txd_n   = parity;
                        state_n = PARITY;
`else
                        txd_n   = UART_IDLE_LEVEL;
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                        txd_n = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    txd_n   = UART_IDLE_LEVEL;
                    state_n = STOP;
                end
            end
`endif
            // idx is reused to count stop bits.
            STOP: begin
                if (tick) begin
                    if (idx == 3'(STOP_BITS - 1)) begin
                        idx_n     = '0;
                        t_state_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            default: begin
                txd_n     = UART_IDLE_LEVEL;
                t_state_n = 1'b1;
                state_n   = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter on the peripheral side of the UART transmit registers: data byte (reg 4), control bit (reg 6), status bit (reg 5).
- Captures the byte on a 0->1 edge of the control bit.
- Serializes 8N1 (parity optional), LSB first, on txd.
- Reports ready/busy on t_state.
- Sits between the MMIO register block and the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  reset; asynchronous, active-high.
t_data  input  8  byte to send; sampled only on the launch cycle.
t_ctrl  input  1  start request; level from MMIO, acted on at its rising edge.
t_state  output  1  1 = idle/ready, 0 = frame in progress.
txd  output  1  serial line; idle high.

Behaviour:
- Reset (async, any time, including mid-frame):
  - txd=1, t_state=1, FSM=IDLE, baud counter=0, bit index=0, shift register=0.
  - The ctrl_q edge register resets to 1, so a t_ctrl held high through reset does NOT launch a frame.
- Edge detect: launch = t_ctrl & ~ctrl_q; ctrl_q <= t_ctrl every posedge.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE + launch: at that posedge, shift<=t_data, txd<=0, t_state<=0, cnt<=0, go START. No other IDLE exit.
  - Bit timing: every non-IDLE state holds its txd value for exactly CLKS_PER_BIT cycles. cnt counts 0..CLKS_PER_BIT-1; the terminal count advances the state and clears cnt.
  - START -> DATA: txd<=shift[0].
  - DATA: on each terminal count, shift right, idx++, txd<=next bit. After bit 7, go to PARITY (if enabled) or STOP with txd<=1.
  - STOP: lasts STOP_BITS*CLKS_PER_BIT cycles. On its final terminal count: t_state<=1, go IDLE. txd stays 1.
- Latency: txd falls in the first cycle after the launch posedge. Frame length = (10 + parity + STOP_BITS-1)*CLKS_PER_BIT cycles. t_state is 0 for exactly that many cycles.
- Boundary rules:
  - Launch edge while not IDLE: ignored, not queued.
  - t_ctrl held high after a frame: no retrigger; software must write 0 then 1.
  - t_ctrl rising in the same cycle the FSM returns to IDLE: ignored (FSM not yet IDLE).
  - t_data changes mid-frame: no effect on the frame in progress.
  - t_ctrl pulse of one cycle: sufficient to launch.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state follows DATA. txd = even parity, i.e. XOR of the captured byte (computed at launch, held in a register). Frame grows by one bit time.
- Undefined: PARITY state and register are not compiled; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg:
  - uart_tx_state_t enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding.
  - UART_DATA_BITS=8.
  - UART_DEFAULT_CLKS_PER_BIT=434.
  - UART_IDLE_LEVEL=1'b1.
- Sub-module uart_baud_gen: cycle counter with clear input and terminal-count tick output, parameterized by CLKS_PER_BIT. The receiver reuses it later.

Test Plan:
1. CLKS_PER_BIT=4, t_data=0x55, pulse t_ctrl -> txd per 4-cycle slot: 0,1,0,1,0,1,0,1,0,1; t_state=0 for exactly 40 cycles, then 1.
2. t_data=0xA3, t_ctrl held high for 100 cycles -> exactly one frame (0,1,1,0,0,0,1,0,1,1); no second start bit while held.
3. Mid-frame (cycle 15 of 0x0F): change t_data to 0xFF and toggle t_ctrl 0->1 -> frame bits unchanged, no second frame; t_state returns 1 at cycle 40.
4. Assert rst at cycle 18 of a frame -> txd=1 and t_state=1 immediately, before the next clk edge. With t_ctrl held high through reset release, txd stays 1 for 50 cycles.
5. STOP_BITS=2, t_data=0x00 -> txd low for 36 cycles, high for 8 cycles; t_state low for 44 cycles.
6. UART_TX_PARITY_EN defined, t_data=0x07 -> parity slot txd=1, frame 44 cycles. With t_data=0x03 -> parity slot txd=0.
